// File: rtl/kuznechik_mode_engine.sv
// rtl/kuznechik_mode_engine.sv - ECB/CBC/CTR mode engine with input/output FIFOs around a kuznechik_cipher core
module kuznechik_mode_engine #(
    parameter int BLOCK_W    = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int CTR_W      = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         mode_i,
    input  logic [BLOCK_W-1:0] iv_i,
    input  logic               start_i,
    input  logic [BLOCK_W-1:0] in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [BLOCK_W-1:0] out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [BLOCK_W-1:0] core_data_o,
    output logic               core_request_o,
    input  logic [BLOCK_W-1:0] core_data_i,
    input  logic               core_valid_i,
    output logic               core_ack_o,
    input  logic               core_busy_i,
    output logic               busy_o,
    output logic [15:0]        blk_cnt_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    localparam logic [1:0] MODE_ECB = 2'd0;
    localparam logic [1:0] MODE_CBC = 2'd1;
    localparam logic [1:0] MODE_CTR = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_NB = 2'd1,
        S_WAIT_V  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]         mode;
    logic [BLOCK_W-1:0] chain;
    logic [BLOCK_W-1:0] p_reg;

    logic issue, done, req_nxt, ack_nxt, start_ok;

    // Input FIFO: pointers carry one extra wrap bit to tell full from empty
    logic [BLOCK_W-1:0] ififo [FIFO_DEPTH];
    logic [AW:0]        iwr, ird;
    logic               iempty, ifull, in_push;
    logic [BLOCK_W-1:0] ihead;

    assign iempty  = (iwr == ird);
    assign ifull   = (iwr[AW] != ird[AW]) && (iwr[AW-1:0] == ird[AW-1:0]);
    assign in_push = in_valid_i && !ifull;
    assign ihead   = ififo[ird[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (in_push)
            ififo[iwr[AW-1:0]] <= in_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iwr <= '0;
            ird <= '0;
        end else begin
            if (in_push) iwr <= iwr + PTR_ONE;
            if (issue)   ird <= ird + PTR_ONE;
        end
    end

    // Output FIFO
    logic [BLOCK_W-1:0] ofifo [FIFO_DEPTH];
    logic [AW:0]        owr, ord;
    logic               oempty, ofull, out_pop;
    logic [BLOCK_W-1:0] result;

    assign oempty  = (owr == ord);
    assign ofull   = (owr[AW] != ord[AW]) && (owr[AW-1:0] == ord[AW-1:0]);
    assign out_pop = !oempty && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (done)
            ofifo[owr[AW-1:0]] <= result;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owr <= '0;
            ord <= '0;
        end else begin
            if (done)    owr <= owr + PTR_ONE;
            if (out_pop) ord <= ord + PTR_ONE;
        end
    end

    assign in_ready_o  = !ifull;
    assign out_valid_o = !oempty;
    assign out_data_o  = oempty ? '0 : ofifo[ord[AW-1:0]];
    assign busy_o      = !iempty || (state != S_IDLE);
    assign start_ok    = start_i && !busy_o && oempty;

    // CTR keeps the high part of the chain fixed and wraps only the low CTR_W bits
    logic [BLOCK_W-1:0] chain_inc;
    always_comb begin
        chain_inc = chain;
        chain_inc[CTR_W-1:0] = chain[CTR_W-1:0] + CTR_W'(1);
    end

    logic [BLOCK_W-1:0] issue_data;
    always_comb begin
        case (mode)
            MODE_CBC: issue_data = ihead ^ chain;
            MODE_CTR: issue_data = chain;
            default:  issue_data = ihead;
        endcase
    end

    assign result = (mode == MODE_CTR) ? (p_reg ^ core_data_i) : core_data_i;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done      = 1'b0;
        req_nxt   = 1'b0;
        ack_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!iempty && !ofull) begin
                    issue     = 1'b1;
                    state_nxt = S_WAIT_NB;
                end
            end
            S_WAIT_NB: begin
                if (!core_busy_i) begin
                    req_nxt   = 1'b1;
                    state_nxt = S_WAIT_V;
                end
            end
            S_WAIT_V: begin
                if (core_valid_i) begin
                    done      = 1'b1;
                    ack_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            core_request_o <= 1'b0;
            core_ack_o     <= 1'b0;
            core_data_o    <= '0;
            p_reg          <= '0;
        end else begin
            state          <= state_nxt;
            core_request_o <= req_nxt;
            core_ack_o     <= ack_nxt;
            if (issue) begin
                core_data_o <= issue_data;
                p_reg       <= ihead;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode      <= MODE_ECB;
            chain     <= '0;
            blk_cnt_o <= '0;
        end else if (start_ok) begin
            mode      <= mode_i;
            chain     <= iv_i;
            blk_cnt_o <= '0;
        end else if (done) begin
            blk_cnt_o <= blk_cnt_o + 16'd1;
            if (mode == MODE_CBC)
                chain <= result;
            else if (mode == MODE_CTR)
                chain <= chain_inc;
        end
    end

endmodule

// File: tb/tb_kuznechik_mode_engine.sv
// tb/tb_kuznechik_mode_engine.sv - directed bench for kuznechik_mode_engine with an inverting stub core
module tb_kuznechik_mode_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   mode = 2'd0;
    logic [127:0] iv = '0;
    logic         start = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] core_data_o;
    logic         core_request;
    logic [127:0] core_res = '0;
    logic         core_valid = 1'b0;
    logic         core_ack;
    logic         core_busy = 1'b0;
    logic         busy;
    logic [15:0]  blk_cnt;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int ack_cnt = 0;
    logic [127:0] core_in [$];

    always #5 clk = ~clk;

    kuznechik_mode_engine dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .mode_i         (mode),
        .iv_i           (iv),
        .start_i        (start),
        .in_data_i      (in_data),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .out_data_o     (out_data),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .core_data_o    (core_data_o),
        .core_request_o (core_request),
        .core_data_i    (core_res),
        .core_valid_i   (core_valid),
        .core_ack_o     (core_ack),
        .core_busy_i    (core_busy),
        .busy_o         (busy),
        .blk_cnt_o      (blk_cnt)
    );

    // Stub core: f(x)=~x, result valid 3 cycles after the request, busy until acked
    initial begin : stub_core
        logic         req_s, ack_s;
        logic [127:0] dat_s;
        int           cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            req_s = core_request;
            ack_s = core_ack;
            dat_s = core_data_o;
            @(posedge clk);
            #1;
            if (rst) begin
                core_busy  = 1'b0;
                core_valid = 1'b0;
                cnt        = 0;
            end else begin
                if (ack_s) begin
                    ack_cnt++;
                    core_valid = 1'b0;
                    core_busy  = 1'b0;
                end
                if (req_s) begin
                    req_cnt++;
                    core_in.push_back(dat_s);
                    core_res  = ~dat_s;
                    core_busy = 1'b1;
                    cnt       = 3;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) core_valid = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] m, input logic [127:0] v);
        @(negedge clk);
        mode  = m;
        iv    = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic try_push(input logic [127:0] d, input int bound, output bit ok);
        int t = 0;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && t < bound) begin
            @(negedge clk);
            t++;
        end
        ok = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push(input string tag, input logic [127:0] d);
        bit ok;
        try_push(d, 200, ok);
        if (!ok) chk(tag, 128'(ok), 128'd1);
    endtask

    task automatic expect_out(input string tag, input logic [127:0] exp);
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(tag, out_valid ? out_data : 128'hx, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : main
        bit ok;
        int acc;
        int t;
        logic [127:0] v;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_request", 128'(core_request), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_blk_cnt", 128'(blk_cnt), 128'd0);

        // ECB single block, with request latency check
        do_start(2'd0, 128'd0);
        req_cnt = 0; ack_cnt = 0; core_in.delete();
        push("ecb_push", 128'h1);
        @(negedge clk);
        chk("ecb_req_lat1", 128'(core_request), 128'd0);
        @(negedge clk);
        chk("ecb_req_lat2", 128'(core_request), 128'd0);
        @(negedge clk);
        chk("ecb_req_lat3", 128'(core_request), 128'd1);
        chk("ecb_core_data", core_data_o, 128'h1);
        expect_out("ecb_out", 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
        idle_cycles(3);
        chk("ecb_req_cnt", 128'(req_cnt), 128'd1);
        chk("ecb_ack_cnt", 128'(ack_cnt), 128'd1);
        chk("ecb_blk_cnt", 128'(blk_cnt), 128'd1);

        // CBC two blocks
        do_start(2'd1, 128'h0F);
        chk("cbc_blk_cnt_clr", 128'(blk_cnt), 128'd0);
        core_in.delete();
        push("cbc_push0", 128'h01);
        push("cbc_push1", 128'h02);
        expect_out("cbc_out0", 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
        expect_out("cbc_out1", 128'h0C);
        idle_cycles(3);
        chk("cbc_core_n", 128'(core_in.size()), 128'd2);
        if (core_in.size() == 2) begin
            chk("cbc_core_in0", core_in[0], 128'h0E);
            chk("cbc_core_in1", core_in[1], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF3);
        end
        chk("cbc_blk_cnt", 128'(blk_cnt), 128'd2);

        // CTR with low-half wrap; a start while busy must be ignored
        do_start(2'd2, {64'h1, 64'hFFFF_FFFF_FFFF_FFFF});
        core_in.delete();
        push("ctr_push0", 128'h0);
        do_start(2'd0, 128'h0);
        push("ctr_push1", 128'h0);
        push("ctr_push2", 128'h5A);
        expect_out("ctr_out0", {64'hFFFF_FFFF_FFFF_FFFE, 64'h0});
        expect_out("ctr_out1", {64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF});
        expect_out("ctr_out2", {64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFA4});
        idle_cycles(3);
        chk("ctr_core_n", 128'(core_in.size()), 128'd3);
        if (core_in.size() == 3) begin
            chk("ctr_core_in0", core_in[0], {64'h1, 64'hFFFF_FFFF_FFFF_FFFF});
            chk("ctr_core_in1", core_in[1], {64'h1, 64'h0});
            chk("ctr_core_in2", core_in[2], {64'h1, 64'h1});
        end
        chk("ctr_blk_cnt", 128'(blk_cnt), 128'd3);

        // Backpressure: 10 offered, 8 fit (4 output + 4 input)
        do_start(2'd0, 128'h0);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            try_push(128'(100 + i), 60, ok);
            if (ok) acc++;
        end
        chk("bp_accepted", 128'(acc), 128'd8);
        @(negedge clk);
        chk("bp_in_ready", 128'(in_ready), 128'd0);
        for (int i = 0; i < 8; i++) begin
            v = 128'(100 + i);
            expect_out($sformatf("bp_out%0d", i), ~v);
        end
        idle_cycles(20);
        chk("bp_drained", 128'(out_valid), 128'd0);
        chk("bp_blk_cnt", 128'(blk_cnt), 128'd8);

        // Reset while a block is in WAIT_V and both FIFOs hold data
        do_start(2'd0, 128'h0);
        req_cnt = 0;
        push("mid_push0", 128'h11);
        push("mid_push1", 128'h22);
        push("mid_push2", 128'h33);
        t = 0;
        while (req_cnt < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("mid_second_req", 128'(req_cnt), 128'd2);
        chk("mid_pre_out_valid", 128'(out_valid), 128'd1);
        chk("mid_pre_blk_cnt", 128'(blk_cnt), 128'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_in_ready", 128'(in_ready), 128'd1);
        chk("mid_out_valid", 128'(out_valid), 128'd0);
        chk("mid_busy", 128'(busy), 128'd0);
        chk("mid_blk_cnt", 128'(blk_cnt), 128'd0);
        chk("mid_core_data", core_data_o, 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);
        do_start(2'd0, 128'h0);
        push("post_push", 128'h0);
        expect_out("post_out", 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
        idle_cycles(3);
        chk("post_blk_cnt", 128'(blk_cnt), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
